// File: rtl/rvfi_retire_monitor_if.sv
// RVFI retirement bundle as seen by the retire monitor.
// The core side drives it (master); the monitor only observes it (slave).
interface rvfi_retire_monitor_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ORDER_W = 64
);
  logic               rvfi_valid;
  logic [ORDER_W-1:0] rvfi_order;
  logic [XLEN-1:0]    rvfi_pc_rdata;
  logic [XLEN-1:0]    rvfi_pc_wdata;
  logic               rvfi_trap;
  logic               rvfi_halt;
  logic               rvfi_intr;

  modport master (
    output rvfi_valid,
    output rvfi_order,
    output rvfi_pc_rdata,
    output rvfi_pc_wdata,
    output rvfi_trap,
    output rvfi_halt,
    output rvfi_intr
  );

  modport slave (
    input rvfi_valid,
    input rvfi_order,
    input rvfi_pc_rdata,
    input rvfi_pc_wdata,
    input rvfi_trap,
    input rvfi_halt,
    input rvfi_intr
  );
endinterface

// File: rtl/rvfi_retire_monitor.sv
// Cross-instruction RVFI checker: PC continuity, strictly incrementing order and a
// retirement watchdog, reported as sticky flags usable from formal and simulation.
module rvfi_retire_monitor #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ORDER_W    = 64,
  parameter int unsigned HANG_LIMIT = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  rvfi_retire_monitor_if.slave rvfi,
  output logic [CNT_W-1:0]     retire_count,
  output logic                 err_pc,
  output logic                 err_order,
  output logic                 err_hang,
  output logic                 err_any,
  output logic [ORDER_W-1:0]   first_err_order
);

  localparam int unsigned HangW = $clog2(HANG_LIMIT + 1);
  localparam logic [HangW-1:0] HangMax  = HangW'(HANG_LIMIT);
  localparam logic [HangW-1:0] HangLast = HangW'(HANG_LIMIT - 1);

  typedef enum logic [1:0] {
    MonIdle,
    MonRun,
    MonHalt
  } mon_state_e;

  mon_state_e         state_q;
  logic [XLEN-1:0]    exp_pc_q;
  logic [ORDER_W-1:0] exp_order_q;
  logic [HangW-1:0]   hang_cnt_q;
  logic [CNT_W-1:0]   retire_count_q;
  logic               err_pc_q;
  logic               err_order_q;
  logic               err_hang_q;
  logic [ORDER_W-1:0] first_err_order_q;

  logic               valid;
  logic [ORDER_W-1:0] order;
  logic               accept;
  logic               pc_bad;
  logic               order_bad;
  logic               hang_hit;
  logic               new_err;
  logic               err_any_q;

  assign valid = rvfi.rvfi_valid;
  assign order = rvfi.rvfi_order;

  // Per-edge violation detection for the current state.
  always_comb begin
    pc_bad    = 1'b0;
    order_bad = 1'b0;
    hang_hit  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      MonIdle: begin
        accept    = valid;
        order_bad = valid && (order != '0);
      end
      MonRun: begin
        accept    = valid;
        // rvfi_intr marks a trap-handler entry, so the PC jump is legitimate there.
        pc_bad    = valid && (rvfi.rvfi_pc_rdata != exp_pc_q) && !rvfi.rvfi_intr;
        order_bad = valid && (order != exp_order_q);
        hang_hit  = !valid && (hang_cnt_q == HangLast);
      end
      MonHalt: begin
        order_bad = valid;
      end
      default: begin
        accept = 1'b0;
      end
    endcase
  end

  assign new_err   = pc_bad || order_bad || hang_hit;
  assign err_any_q = err_pc_q || err_order_q || err_hang_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= MonIdle;
      exp_pc_q          <= '0;
      exp_order_q       <= '0;
      hang_cnt_q        <= '0;
      retire_count_q    <= '0;
      err_pc_q          <= 1'b0;
      err_order_q       <= 1'b0;
      err_hang_q        <= 1'b0;
      first_err_order_q <= '0;
    end else begin
      if (pc_bad) begin
        err_pc_q <= 1'b1;
      end
      if (order_bad) begin
        err_order_q <= 1'b1;
      end
      if (hang_hit) begin
        err_hang_q <= 1'b1;
      end
      // A hang has no retiring instruction, so the order it was waiting for is recorded.
      if (new_err && !err_any_q) begin
        first_err_order_q <= hang_hit ? exp_order_q : order;
      end

      if (accept) begin
        exp_pc_q       <= rvfi.rvfi_pc_wdata;
        exp_order_q    <= order + ORDER_W'(1);
        retire_count_q <= retire_count_q + CNT_W'(1);
        hang_cnt_q     <= '0;
        state_q        <= rvfi.rvfi_halt ? MonHalt : MonRun;
      end else if ((state_q == MonRun) && !valid && (hang_cnt_q != HangMax)) begin
        hang_cnt_q <= hang_cnt_q + HangW'(1);
      end
    end
  end

  assign retire_count    = retire_count_q;
  assign err_pc          = err_pc_q;
  assign err_order       = err_order_q;
  assign err_hang        = err_hang_q;
  assign err_any         = err_any_q;
  assign first_err_order = first_err_order_q;

endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// Scoreboard bench for rvfi_retire_monitor: a behavioural model pushes expected outputs
// as each cycle is driven; they are popped and compared one edge later.
module tb_rvfi_retire_monitor;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ORDER_W    = 64;
  localparam int unsigned HANG_LIMIT = 16;
  localparam int unsigned CNT_W      = 32;

  typedef struct packed {
    logic [CNT_W-1:0]   cnt;
    logic               epc;
    logic               eord;
    logic               ehang;
    logic               eany;
    logic [ORDER_W-1:0] first;
  } exp_t;

  logic clock;
  logic reset;

  logic [CNT_W-1:0]   retire_count;
  logic               err_pc;
  logic               err_order;
  logic               err_hang;
  logic               err_any;
  logic [ORDER_W-1:0] first_err_order;

  int n_checks;
  int n_errors;
  exp_t sb_q[$];

  // Model state: 0 idle, 1 run, 2 halt.
  int                 m_state;
  logic [XLEN-1:0]    m_exp_pc;
  logic [ORDER_W-1:0] m_exp_order;
  int                 m_hang;
  logic [CNT_W-1:0]   m_cnt;
  logic               m_epc;
  logic               m_eord;
  logic               m_ehang;
  logic [ORDER_W-1:0] m_first;

  rvfi_retire_monitor_if #(.XLEN(XLEN), .ORDER_W(ORDER_W)) rvfi_bus ();

  rvfi_retire_monitor #(
    .XLEN       (XLEN),
    .ORDER_W    (ORDER_W),
    .HANG_LIMIT (HANG_LIMIT),
    .CNT_W      (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rvfi            (rvfi_bus.slave),
    .retire_count    (retire_count),
    .err_pc          (err_pc),
    .err_order       (err_order),
    .err_hang        (err_hang),
    .err_any         (err_any),
    .first_err_order (first_err_order)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state     = 0;
    m_exp_pc    = '0;
    m_exp_order = '0;
    m_hang      = 0;
    m_cnt       = '0;
    m_epc       = 1'b0;
    m_eord      = 1'b0;
    m_ehang     = 1'b0;
    m_first     = '0;
  endtask

  task automatic model_step(input logic v, input logic [ORDER_W-1:0] ord,
                            input logic [XLEN-1:0] pcr, input logic [XLEN-1:0] pcw,
                            input logic halt, input logic intr);
    logic bad_pc;
    logic bad_ord;
    logic bad_hang;
    logic any_before;
    any_before = m_epc | m_eord | m_ehang;
    bad_pc   = 1'b0;
    bad_ord  = 1'b0;
    bad_hang = 1'b0;
    if (v && m_state == 2) begin
      bad_ord = 1'b1;
    end else if (v) begin
      if (m_state == 0) begin
        bad_ord = (ord != 0);
      end else begin
        bad_pc  = (pcr != m_exp_pc) && !intr;
        bad_ord = (ord != m_exp_order);
      end
    end else if (m_state == 1 && m_hang < HANG_LIMIT) begin
      m_hang++;
      bad_hang = (m_hang == HANG_LIMIT);
    end
    if (!any_before && (bad_pc || bad_ord || bad_hang)) begin
      m_first = bad_hang ? m_exp_order : ord;
    end
    if (v && m_state != 2) begin
      m_exp_pc    = pcw;
      m_exp_order = ord + 1;
      m_cnt       = m_cnt + 1;
      m_hang      = 0;
      m_state     = halt ? 2 : 1;
    end
    m_epc   = m_epc | bad_pc;
    m_eord  = m_eord | bad_ord;
    m_ehang = m_ehang | bad_hang;
  endtask

  // Drive one cycle, predict its result, then compare right after the edge.
  task automatic step(input logic v, input logic [ORDER_W-1:0] ord,
                      input logic [XLEN-1:0] pcr, input logic [XLEN-1:0] pcw,
                      input logic trap, input logic halt, input logic intr);
    exp_t e;
    exp_t got_e;
    @(negedge clock);
    rvfi_bus.rvfi_valid    = v;
    rvfi_bus.rvfi_order    = ord;
    rvfi_bus.rvfi_pc_rdata = pcr;
    rvfi_bus.rvfi_pc_wdata = pcw;
    rvfi_bus.rvfi_trap     = trap;
    rvfi_bus.rvfi_halt     = halt;
    rvfi_bus.rvfi_intr     = intr;
    model_step(v, ord, pcr, pcw, halt, intr);
    e.cnt   = m_cnt;
    e.epc   = m_epc;
    e.eord  = m_eord;
    e.ehang = m_ehang;
    e.eany  = m_epc | m_eord | m_ehang;
    e.first = m_first;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'd0, 64'd1);
    end else begin
      got_e = sb_q.pop_front();
      check("retire_count", 64'(retire_count), 64'(got_e.cnt));
      check("err_pc", 64'(err_pc), 64'(got_e.epc));
      check("err_order", 64'(err_order), 64'(got_e.eord));
      check("err_hang", 64'(err_hang), 64'(got_e.ehang));
      check("err_any", 64'(err_any), 64'(got_e.eany));
      check("first_err_order", 64'(first_err_order), 64'(got_e.first));
    end
  endtask

  task automatic retire(input logic [ORDER_W-1:0] ord, input logic [XLEN-1:0] pc,
                        input logic halt, input logic intr);
    step(1'b1, ord, pc, pc + 4, 1'b0, halt, intr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"}, 64'(retire_count), 64'd0);
    check({tag, "_err_any"}, 64'(err_pc | err_order | err_hang | err_any), 64'd0);
    check({tag, "_first"}, 64'(first_err_order), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    rvfi_bus.rvfi_valid = 1'b0;
    #2;
    model_reset();
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    rvfi_bus.rvfi_valid    = 1'b0;
    rvfi_bus.rvfi_order    = '0;
    rvfi_bus.rvfi_pc_rdata = '0;
    rvfi_bus.rvfi_pc_wdata = '0;
    rvfi_bus.rvfi_trap     = 1'b0;
    rvfi_bus.rvfi_halt     = 1'b0;
    rvfi_bus.rvfi_intr     = 1'b0;
    model_reset();

    // Boot latency is not watched.
    do_reset();
    idle(100);
    check_all_zero("boot_idle");

    // Clean sequence, one trapped instruction included.
    do_reset();
    retire(0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1, 32'h4, 32'h8, 1'b1, 1'b0, 1'b0);
    retire(2, 32'h8, 1'b0, 1'b0);
    retire(3, 32'hC, 1'b0, 1'b0);
    check("seq_cnt", 64'(retire_count), 64'd4);
    check("seq_err_any", 64'(err_any), 64'd0);

    // PC discontinuity, then the same jump marked as interrupt entry.
    do_reset();
    retire(0, 32'h0, 1'b0, 1'b0);
    retire(1, 32'h10, 1'b0, 1'b0);
    check("pc_err", 64'(err_pc), 64'd1);
    check("pc_first", 64'(first_err_order), 64'd1);
    do_reset();
    retire(0, 32'h0, 1'b0, 1'b0);
    retire(1, 32'h10, 1'b0, 1'b1);
    check("intr_err_any", 64'(err_any), 64'd0);

    // Order skip; the later correct order leaves the capture alone.
    do_reset();
    retire(0, 32'h0, 1'b0, 1'b0);
    retire(2, 32'h4, 1'b0, 1'b0);
    check("ord_err", 64'(err_order), 64'd1);
    check("ord_first", 64'(first_err_order), 64'd2);
    retire(3, 32'h8, 1'b0, 1'b0);
    check("ord_err_sticky", 64'(err_order), 64'd1);
    check("ord_first_kept", 64'(first_err_order), 64'd2);
    // Second error of a different kind does not recapture.
    retire(4, 32'h40, 1'b0, 1'b0);
    check("ord_first_kept2", 64'(first_err_order), 64'd2);

    // Watchdog boundary: 16th idle edge fires, 15 does not.
    do_reset();
    retire(0, 32'h0, 1'b0, 1'b0);
    idle(15);
    check("hang_15", 64'(err_hang), 64'd0);
    idle(1);
    check("hang_16", 64'(err_hang), 64'd1);
    check("hang_first", 64'(first_err_order), 64'd1);
    idle(5);
    do_reset();
    retire(0, 32'h0, 1'b0, 1'b0);
    idle(15);
    retire(1, 32'h4, 1'b0, 1'b0);
    idle(15);
    check("hang_rearm", 64'(err_any), 64'd0);

    // Retirement after halt is an order error and is not counted; no watchdog.
    do_reset();
    retire(0, 32'h0, 1'b1, 1'b0);
    idle(30);
    check("halt_no_hang", 64'(err_hang), 64'd0);
    retire(1, 32'h4, 1'b0, 1'b0);
    check("halt_ord", 64'(err_order), 64'd1);
    check("halt_cnt", 64'(retire_count), 64'd1);

    // Async reset mid-run, then a fresh first retirement.
    do_reset();
    retire(0, 32'h0, 1'b0, 1'b0);
    retire(5, 32'h20, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    rvfi_bus.rvfi_valid = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    @(negedge clock);
    reset = 1'b1;
    retire(0, 32'h100, 1'b0, 1'b0);
    retire(1, 32'h104, 1'b0, 1'b0);
    check("post_rst_cnt", 64'(retire_count), 64'd2);
    check("post_rst_err", 64'(err_any), 64'd0);

    if (sb_q.size() != 0) begin
      check("sb_leftover", 64'(sb_q.size()), 64'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
